button_event_gen: RTL

BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

---
 rtl/button_event_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/button_event_gen.sv
// button_event_gen: five independent push-button channels. Each channel
// synchronizes its raw input, debounces it into a registered level and turns
// debounced presses into one-cycle event pulses, with optional auto-repeat
// while the button stays held.
module button_event_gen #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000,
   parameter int REPEAT_EN       = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] button_in,
   output logic [4:0] button_out,
   output logic [4:0] button_level
);

   // The stability counter counts the differing samples and the level is
   // accepted on the edge after it has seen DEBOUNCE_CYCLES of them, which
   // together with the two synchronizer flops gives the 2+DEBOUNCE_CYCLES
   // latency from the first sampling edge.
   localparam int DB_RAW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DBW    = (DB_RAW > 1) ? DB_RAW : 1;
   localparam int RD_RAW = $clog2(REPEAT_DELAY);
   localparam int RP_RAW = $clog2(REPEAT_PERIOD);
   localparam int RC_RAW = (RD_RAW > RP_RAW) ? RD_RAW : RP_RAW;
   localparam int RCW    = (RC_RAW > 1) ? RC_RAW : 1;

   localparam logic [DBW-1:0] DB_TERM = DBW'(DEBOUNCE_CYCLES);
   localparam logic [RCW-1:0] RD_TERM = RCW'(REPEAT_DELAY - 1);
   localparam logic [RCW-1:0] RP_TERM = RCW'(REPEAT_PERIOD - 1);
   localparam logic           RPT_ON  = (REPEAT_EN != 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   logic [4:0] sync1_q;
   logic [4:0] sync2_q;

   // Two-flop synchronizer for all raw button inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 5'b00000;
         sync2_q <= 5'b00000;
      end else begin
         sync1_q <= button_in;
         sync2_q <= sync1_q;
      end
   end

   for (genvar ch = 0; ch < 5; ch++) begin : g_ch
      logic [DBW-1:0] dcnt_q, dcnt_d;
      logic           level_q, level_d;
      logic [RCW-1:0] rcnt_q, rcnt_d;
      logic           out_q, out_d;
      state_t         state_q, state_d;
      logic           diff_s, accept_s, rise_s, fall_s;

      assign diff_s   = sync2_q[ch] ^ level_q;
      assign accept_s = diff_s && (dcnt_q == DB_TERM);
      assign rise_s   = accept_s && !level_q;
      assign fall_s   = accept_s && level_q;

      // Debounce: count consecutive differing samples, toggle the level once stable.
      always_comb begin
         dcnt_d  = dcnt_q;
         level_d = level_q;
         if (!diff_s) begin
            dcnt_d = {DBW{1'b0}};
         end else if (accept_s) begin
            dcnt_d  = {DBW{1'b0}};
            level_d = ~level_q;
         end else begin
            dcnt_d = dcnt_q + DBW'(1);
         end
      end

      // Next-state logic of the press / auto-repeat state machine.
      always_comb begin
         state_d = state_q;
         case (state_q)
            ST_IDLE: begin
               if (rise_s) begin
                  state_d = ST_DELAY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DELAY: begin
               if (fall_s) begin
                  state_d = ST_IDLE;
               end else if (RPT_ON && (rcnt_q == RD_TERM)) begin
                  state_d = ST_REPEAT;
               end else begin
                  state_d = ST_DELAY;
               end
            end
            ST_REPEAT: begin
               if (fall_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_REPEAT;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Output logic: event pulse and repeat counter; a release wins over a due repeat.
      always_comb begin
         out_d  = 1'b0;
         rcnt_d = rcnt_q;
         case (state_q)
            ST_IDLE: begin
               rcnt_d = {RCW{1'b0}};
               out_d  = rise_s;
            end
            ST_DELAY: begin
               if (fall_s) begin
                  rcnt_d = {RCW{1'b0}};
               end else if (!RPT_ON) begin
                  rcnt_d = {RCW{1'b0}};
               end else if (rcnt_q == RD_TERM) begin
                  rcnt_d = {RCW{1'b0}};
                  out_d  = 1'b1;
               end else begin
                  rcnt_d = rcnt_q + RCW'(1);
               end
            end
            ST_REPEAT: begin
               if (fall_s) begin
                  rcnt_d = {RCW{1'b0}};
               end else if (rcnt_q == RP_TERM) begin
                  rcnt_d = {RCW{1'b0}};
                  out_d  = 1'b1;
               end else begin
                  rcnt_d = rcnt_q + RCW'(1);
               end
            end
            default: begin
               rcnt_d = {RCW{1'b0}};
               out_d  = 1'b0;
            end
         endcase
      end

      // Channel state register: counters, level, FSM state and output pulse.
      always_ff @(posedge clk) begin
         if (reset) begin
            dcnt_q  <= {DBW{1'b0}};
            level_q <= 1'b0;
            rcnt_q  <= {RCW{1'b0}};
            out_q   <= 1'b0;
            state_q <= ST_IDLE;
         end else begin
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
            rcnt_q  <= rcnt_d;
            out_q   <= out_d;
            state_q <= state_d;
         end
      end

      assign button_out[ch]   = out_q;
      assign button_level[ch] = level_q;
   end

endmodule
